// File: rtl/ps2_wasd_receiver.sv
// PS/2 scan-code set 2 receiver that turns W/A/S/D and arrow make/break codes into held-key levels.
// Latency: key_valid, scan_code and w/a/s/d update one clk after the stop-bit edge is detected.
module ps2_wasd_receiver #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       w,
  output logic       a,
  output logic       s,
  output logic       d,
  output logic [7:0] scan_code,
  output logic       key_valid,
  output logic       frame_error
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
  logic                   clk_prev_q;
  logic                   ps2_clk_s, ps2_data_s, fall;

  state_t         state_q, state_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     shift_q, shift_d;
  logic           parity_q, parity_d;
  logic [CW-1:0]  to_cnt_q, to_cnt_d;
  logic           stop_good, stop_bad, timeout;

  logic           ext_q, ext_d, brk_q, brk_d;
  logic [7:0]     held_q, held_d, key_hit;
  logic [7:0]     scan_q, scan_d;
  logic           kv_q, fe_q;

  // Lines idle high, so the chain resets to 1 to avoid a false edge after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
      clk_prev_q  <= clk_sync_q[SYNC_STAGES-1];
    end
  end

  assign ps2_clk_s  = clk_sync_q[SYNC_STAGES-1];
  assign ps2_data_s = data_sync_q[SYNC_STAGES-1];
  assign fall       = clk_prev_q & ~ps2_clk_s;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    stop_good = 1'b0;
    stop_bad  = 1'b0;
    timeout   = 1'b0;
    to_cnt_d  = (state_q == IDLE) ? '0 : to_cnt_q + CW'(1);
    if (fall) begin
      to_cnt_d = '0;
      case (state_q)
        IDLE: begin
          if (!ps2_data_s) begin
            state_d   = DATA;
            bit_cnt_d = 3'd0;
          end
        end
        DATA: begin
          shift_d   = {ps2_data_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          parity_d = ps2_data_s;
          state_d  = STOP;
        end
        default: begin
          state_d = IDLE;
          if (((^shift_q) ^ parity_q) && ps2_data_s) stop_good = 1'b1;
          else                                        stop_bad  = 1'b1;
        end
      endcase
    end else if (state_q != IDLE && to_cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
      timeout  = 1'b1;
      state_d  = IDLE;
      to_cnt_d = '0;
    end
  end

  // Held-bit layout: [3:0] = W A S D letters, [7:4] = Up Left Down Right arrows.
  always_comb begin
    key_hit = 8'h00;
    case ({ext_q, shift_q})
      9'h01D:  key_hit = 8'b0000_0001;
      9'h01C:  key_hit = 8'b0000_0010;
      9'h01B:  key_hit = 8'b0000_0100;
      9'h023:  key_hit = 8'b0000_1000;
      9'h175:  key_hit = 8'b0001_0000;
      9'h16B:  key_hit = 8'b0010_0000;
      9'h172:  key_hit = 8'b0100_0000;
      9'h174:  key_hit = 8'b1000_0000;
      default: key_hit = 8'h00;
    endcase
  end

  always_comb begin
    ext_d  = ext_q;
    brk_d  = brk_q;
    held_d = held_q;
    scan_d = scan_q;
    if (stop_good) begin
      scan_d = shift_q;
      if (shift_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (shift_q == 8'hF0) begin
        brk_d = 1'b1;
      end else begin
        held_d = brk_q ? (held_q & ~key_hit) : (held_q | key_hit);
        ext_d  = 1'b0;
        brk_d  = 1'b0;
      end
    end else if (stop_bad || timeout) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'h00;
      parity_q  <= 1'b0;
      to_cnt_q  <= '0;
      ext_q     <= 1'b0;
      brk_q     <= 1'b0;
      held_q    <= 8'h00;
      scan_q    <= 8'h00;
      kv_q      <= 1'b0;
      fe_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      to_cnt_q  <= to_cnt_d;
      ext_q     <= ext_d;
      brk_q     <= brk_d;
      held_q    <= held_d;
      scan_q    <= scan_d;
      kv_q      <= stop_good;
      fe_q      <= stop_bad | timeout;
    end
  end

  assign w           = held_q[0] | held_q[4];
  assign a           = held_q[1] | held_q[5];
  assign s           = held_q[2] | held_q[6];
  assign d           = held_q[3] | held_q[7];
  assign scan_code   = scan_q;
  assign key_valid   = kv_q;
  assign frame_error = fe_q;

endmodule

// File: tb/tb_ps2_wasd_receiver.sv
// Bench for ps2_wasd_receiver: directed frames plus randomized traffic against a byte-level key model.
module tb_ps2_wasd_receiver;

  localparam int TO  = 500;
  localparam int LAT = 3;  // drive of a ps2_clk fall -> registered outputs (2 sync + 1)

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       w, a, s, d, key_valid, frame_error;
  logic [7:0] scan_code;

  ps2_wasd_receiver #(.TIMEOUT_CYCLES(TO), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .w(w), .a(a), .s(s), .d(d), .scan_code(scan_code),
    .key_valid(key_valid), .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {int at; bit err; logic [7:0] b;} ev_t;
  ev_t evq[$];

  bit         m_held[8];   // 0..3 letters W A S D, 4..7 arrows Up Left Down Right
  bit         m_ext, m_brk;
  logic [7:0] m_scan;
  bit         exp_kv, exp_fe;
  logic [7:0] plain_codes[4] = '{8'h1D, 8'h1C, 8'h1B, 8'h23};
  logic [7:0] ext_codes[4]   = '{8'h75, 8'h6B, 8'h72, 8'h74};

  task automatic model_reset();
    foreach (m_held[i]) m_held[i] = 1'b0;
    m_ext = 0; m_brk = 0; m_scan = 8'h00;
    evq.delete();
  endtask

  task automatic apply_ev(input ev_t e);
    if (e.err) begin
      exp_fe = 1; m_ext = 0; m_brk = 0;
    end else begin
      exp_kv = 1;
      m_scan = e.b;
      if (e.b == 8'hE0) m_ext = 1;
      else if (e.b == 8'hF0) m_brk = 1;
      else begin
        for (int i = 0; i < 4; i++) begin
          if (!m_ext && plain_codes[i] == e.b) m_held[i] = !m_brk;
          if (m_ext && ext_codes[i] == e.b)    m_held[i + 4] = !m_brk;
        end
        m_ext = 0; m_brk = 0;
      end
    end
  endtask

  function automatic int exp_wasd();
    return {m_held[0] | m_held[4], m_held[1] | m_held[5],
            m_held[2] | m_held[6], m_held[3] | m_held[7]};
  endfunction

  bit chk_en = 0;
  int kv_seen = 0, fe_seen = 0, fe_cyc = 0;
  ev_t ev;

  always @(negedge clk) begin
    if (chk_en) begin
      exp_kv = 0; exp_fe = 0;
      while (evq.size() > 0 && evq[0].at <= cyc) begin
        ev = evq.pop_front();
        apply_ev(ev);
      end
      chk("key_valid", key_valid, exp_kv);
      chk("frame_error", frame_error, exp_fe);
      chk("scan_code", scan_code, m_scan);
      chk("wasd", {w, a, s, d}, exp_wasd());
      if (key_valid) kv_seen++;
      if (frame_error) begin fe_seen++; fe_cyc = cyc; end
    end
  end

  // ---------------- driver ----------------
  int last_fall = 0;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // mode: 0 good, 1 bad parity, 2 bad stop, 3 partial (times out), 4 partial without expectation
  task automatic send_frame(input logic [7:0] b, input int mode, input int half);
    logic [10:0] bits;
    int nf;
    bits = {(mode != 2), (~^b) ^ (mode == 1), b, 1'b0};
    nf = (mode >= 3) ? 5 : 11;
    for (int i = 0; i < nf; i++) begin
      ps2_data = bits[i];
      tick(half);
      ps2_clk = 1'b0;
      last_fall = cyc;
      if (i == nf - 1 && mode != 4)
        evq.push_back('{at: cyc + LAT + ((mode == 3) ? TO : 0), err: (mode != 0), b: b});
      tick(half);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    if (mode == 3) tick(TO + 20);
    else           tick(half + 5);
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 0, 20);
  endtask

  logic [7:0] pool[12] = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h75, 8'h6B,
                           8'h72, 8'h74, 8'hE0, 8'hF0, 8'hF0, 8'hAA};

  int kv0, fe0;

  initial begin
    model_reset();
    tick(4);
    chk("rst_scan", scan_code, 8'h00);
    chk("rst_kv", key_valid, 0);
    chk("rst_fe", frame_error, 0);
    chk("rst_wasd", {w, a, s, d}, 0);
    reset = 1'b0;
    tick(2);
    chk_en = 1;

    // make then break of W
    kv0 = kv_seen;
    send(8'h1D);
    chk("w_make", w, 1);
    chk("scan_1D", scan_code, 8'h1D);
    chk("kv_one", kv_seen - kv0, 1);
    kv0 = kv_seen;
    send(8'hF0); send(8'h1D);
    chk("w_break", w, 0);
    chk("kv_two", kv_seen - kv0, 2);

    // Up and W share the w output
    send(8'hE0); send(8'h75);
    chk("w_up", w, 1);
    send(8'h1D);
    chk("w_up_w", w, 1);
    send(8'hE0); send(8'hF0); send(8'h75);
    chk("w_after_up_rel", w, 1);
    send(8'hF0); send(8'h1D);
    chk("w_all_rel", w, 0);
    chk("asd_zero", {a, s, d}, 0);

    // parity error
    kv0 = kv_seen; fe0 = fe_seen;
    send_frame(8'h23, 1, 20);
    chk("par_fe", fe_seen - fe0, 1);
    chk("par_kv", kv_seen - kv0, 0);
    chk("par_d", d, 0);
    chk("par_scan_kept", scan_code, 8'h1D);

    // stop-bit error then good frame
    fe0 = fe_seen;
    send_frame(8'h1C, 2, 20);
    chk("stop_fe", fe_seen - fe0, 1);
    send(8'h1C);
    chk("a_make", a, 1);

    // timeout after 4 data bits
    fe0 = fe_seen;
    send_frame(8'h1B, 3, 20);
    chk("to_fe", fe_seen - fe0, 1);
    chk("to_delay", fe_cyc - (last_fall + LAT), TO);
    send(8'h1B);
    chk("s_make", s, 1);
    send(8'h23);
    chk("sd_held", {s, d}, 2'b11);

    // reset mid-frame
    fe0 = fe_seen;
    send_frame(8'h55, 4, 20);
    tick(10);
    chk_en = 0;
    reset = 1'b1;
    tick(4);
    model_reset();
    reset = 1'b0;
    tick(1);
    chk_en = 1;
    chk("mid_rst_wasd", {w, a, s, d}, 0);
    chk("mid_rst_scan", scan_code, 8'h00);
    kv0 = kv_seen;
    send(8'hAA);
    chk("aa_kv", kv_seen - kv0, 1);
    chk("aa_wasd", {w, a, s, d}, 0);
    chk("aa_scan", scan_code, 8'hAA);
    chk("mid_rst_no_fe", fe_seen - fe0, 0);

    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      int r;
      logic [7:0] b;
      r = $urandom_range(0, 11);
      b = ($urandom_range(0, 7) == 0) ? 8'($urandom) : pool[$urandom_range(0, 11)];
      send_frame(b, (r <= 2) ? r + 1 : 0, $urandom_range(6, 25));
    end
    tick(10);
    chk("queue_drained", evq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

endmodule
